// File: rtl/microsequencer_pkg.sv
// Microsequencer shared definitions: next-address modes and default sizes.
// Imported by the next-address selector and the register top.
package microsequencer_pkg;

  localparam int UADDR_W   = 7;
  localparam int MOC_LIMIT = 255;
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    NS_INC    = 3'b000,
    NS_JUMP   = 3'b001,
    NS_DECODE = 3'b010,
    NS_COND   = 3'b011,
    NS_WAIT   = 3'b100,
    NS_CALL   = 3'b101,
    NS_RET    = 3'b110,
    NS_FETCH  = 3'b111
  } ns_e;

endpackage

// File: rtl/microsequencer_nextaddr.sv
// Combinational next-address selection for the microsequencer.
// Also flags a MOC wait that is still holding.
module microsequencer_nextaddr #(
  parameter int UADDR_W = microsequencer_pkg::UADDR_W
) (
  input  logic [2:0]         ns_i,
  input  logic               inv_i,
  input  logic [UADDR_W-1:0] cr_addr_i,
  input  logic [UADDR_W-1:0] dec_addr_i,
  input  logic               cond_i,
  input  logic               moc_i,
  input  logic [UADDR_W-1:0] index_i,
  input  logic [UADDR_W-1:0] ret_i,
  output logic [UADDR_W-1:0] next_o,
  output logic [UADDR_W-1:0] inc_o,
  output logic               waiting_o
);
  import microsequencer_pkg::*;

  logic cond_pass;
  logic moc_pass;

  // inc wraps naturally at the address width
  assign inc_o     = index_i + 1'b1;
  assign cond_pass = cond_i ^ inv_i;
  assign moc_pass  = moc_i ^ inv_i;
  assign waiting_o = (ns_e'(ns_i) == NS_WAIT) && !moc_pass;

  always_comb begin
    next_o = inc_o;
    unique case (ns_e'(ns_i))
      NS_INC:    next_o = inc_o;
      NS_JUMP:   next_o = cr_addr_i;
      NS_DECODE: next_o = dec_addr_i;
      NS_COND:   next_o = cond_pass ? cr_addr_i : inc_o;
      NS_WAIT:   next_o = moc_pass ? inc_o : index_i;
      NS_CALL:   next_o = cr_addr_i;
      NS_RET:    next_o = ret_i;
      NS_FETCH:  next_o = '0;
      default:   next_o = inc_o;
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// Microsequencer: microstore address register, single-entry return
// register and MOC-wait watchdog with sticky timeout flag.
module microsequencer #(
  parameter int UADDR_W   = microsequencer_pkg::UADDR_W,
  parameter int MOC_LIMIT = microsequencer_pkg::MOC_LIMIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         ns,
  input  logic               inv,
  input  logic [UADDR_W-1:0] cr_addr,
  input  logic [UADDR_W-1:0] dec_addr,
  input  logic               cond,
  input  logic               moc,
  output logic [UADDR_W-1:0] index,
  output logic               waiting,
  output logic               moc_timeout
);
  import microsequencer_pkg::*;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MOC_LIMIT);

  logic [UADDR_W-1:0] index_q, index_d;
  logic [UADDR_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               to_q, to_d;
  logic [UADDR_W-1:0] next;
  logic [UADDR_W-1:0] inc;
  logic               wait_w;

  microsequencer_nextaddr #(
    .UADDR_W (UADDR_W)
  ) u_nextaddr (
    .ns_i       (ns),
    .inv_i      (inv),
    .cr_addr_i  (cr_addr),
    .dec_addr_i (dec_addr),
    .cond_i     (cond),
    .moc_i      (moc),
    .index_i    (index_q),
    .ret_i      (ret_q),
    .next_o     (next),
    .inc_o      (inc),
    .waiting_o  (wait_w)
  );

  always_comb begin
    index_d = next;
    ret_d   = ret_q;
    cnt_d   = '0;
    to_d    = to_q;
    if (ns_e'(ns) == NS_CALL) begin
      ret_d = inc;
    end
    // a stalled memory op abandons the routine and refetches
    if (wait_w && (cnt_q == LIMIT)) begin
      to_d    = 1'b1;
      index_d = '0;
      cnt_d   = '0;
    end else if (wait_w) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      index_q <= '0;
      ret_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      index_q <= index_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign index       = index_q;
  assign waiting     = wait_w;
  assign moc_timeout = to_q;

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 SHALL have parameter UADDR_W, default 7, the microstore address width.
REQ-002 SHALL have parameter MOC_LIMIT, default 255, the maximum number of consecutive MOC-wait cycles before timeout.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ns, input, 3, the next-address mode field of the current microinstruction.
REQ-006 SHALL have port inv, input, 1, the condition-invert bit of the current microinstruction.
REQ-007 SHALL have port cr_addr, input, UADDR_W, the jump target field of the current microinstruction.
REQ-008 SHALL have port dec_addr, input, UADDR_W, the start address supplied by the instruction decoder.
REQ-009 SHALL have port cond, input, 1, the condition-pass flag from the condition tester.
REQ-010 SHALL have port moc, input, 1, memory operation complete.
REQ-011 SHALL have port index, output, UADDR_W, the registered microstore address that drives the control ROM.
REQ-012 SHALL have port waiting, output, 1, high while holding in a MOC wait.
REQ-013 SHALL have port moc_timeout, output, 1, a sticky MOC timeout error flag.

Function
REQ-014 SHALL define inc as (index+1) mod 2^UADDR_W, so 127 wraps to 0.
REQ-015 SHALL load index at each clock edge from the next address selected by ns, per REQ-016..REQ-023; the new index is visible 1 cycle after the fields are sampled.
REQ-016 ns=000 INC SHALL select next=inc.
REQ-017 ns=001 JUMP SHALL select next=cr_addr.
REQ-018 ns=010 DECODE SHALL select next=dec_addr.
REQ-019 ns=011 COND SHALL select next=cr_addr when (cond XOR inv)=1, else next=inc.
REQ-020 ns=100 WAIT SHALL select next=inc when (moc XOR inv)=1, else next=index (hold).
REQ-021 ns=101 CALL SHALL load ret<=inc and select next=cr_addr.
REQ-022 The single-entry return register SHALL be overwritten by a nested CALL.
REQ-023 ns=110 RET SHALL select next=ret; RET with no prior CALL SHALL yield ret's reset value of 0. ns=111 FETCH SHALL select next=0.
REQ-024 waiting SHALL be a combinational output equal to (ns==WAIT) AND (moc XOR inv)==0.
REQ-025 An 8-bit wait counter SHALL increment on every cycle in which waiting=1 and SHALL clear on every other cycle.
REQ-026 When waiting=1 and the counter equals MOC_LIMIT, the next edge SHALL set moc_timeout=1, force index<=0 and clear the counter.
REQ-027 moc_timeout SHALL remain 1 until reset.
REQ-028 If timeout forcing and reset coincide, reset SHALL win.

Reset
REQ-029 When reset=1 at an edge, the block SHALL set index=0, ret=0, counter=0 and moc_timeout=0, regardless of ns and the other inputs.
REQ-030 After reset, waiting SHALL follow REQ-024 immediately.
REQ-031 Reset asserted during a WAIT hold SHALL abandon the wait and restart fetch at address 0 on the next cycle.

Structure
REQ-032 A shared package SHALL hold the ns encodings (NS_INC, NS_JUMP, NS_DECODE, NS_COND, NS_WAIT, NS_CALL, NS_RET, NS_FETCH), UADDR_W and MOC_LIMIT.
REQ-033 The combinational next-address selection SHALL be a sub-module, microsequencer_nextaddr.
REQ-034 The registers (index, ret, counter, moc_timeout) SHALL live in microsequencer.

Verification
REQ-035 INC test: reset, then hold ns=INC for 130 cycles -> index shall run 0,1,...,127,0,1.
REQ-036 COND test: index=5, ns=COND, cr_addr=0x40, cond=1, inv=0 -> index=0x40; repeat with inv=1 -> index=6.
REQ-037 CALL/RET test: index=0x10, ns=CALL, cr_addr=0x50 -> index=0x50; next cycle ns=RET -> index=0x11; RET immediately after reset -> index=0.
REQ-038 WAIT handshake test: index=0x2A, ns=WAIT, moc=0 for 3 cycles, then moc=1 -> index stays 0x2A with waiting=1 for 3 cycles, then index=0x2B and waiting=0.
REQ-039 Timeout test: ns=WAIT with moc=0 held for 260 cycles -> on the 256th edge moc_timeout=1 and index=0; moc_timeout stays 1 until reset clears it.
REQ-040 DECODE/reset test: ns=DECODE, dec_addr=0x5C -> index=0x5C; reset mid-WAIT -> index=0 and counter cleared on the next edge.
